// File: rtl/rr_stream_packer_if.sv
// Unit-in / beat-out stream bundle for rr_stream_packer, including the flush handshake.
interface rr_stream_packer_if #(
  parameter int unsigned LOGB_CHANNEL_CNT = 4,
  parameter int unsigned LOGE_CHANNEL_CNT = 4,
  parameter int unsigned FULL_WIDTH       = 256,
  parameter int unsigned OUT_WIDTH        = 512
);
  localparam int unsigned LEN_W  = $clog2(FULL_WIDTH + 1);
  localparam int unsigned OLEN_W = $clog2(OUT_WIDTH + 1);

  logic                        in_valid;
  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid;
  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid;
  logic [FULL_WIDTH-1:0]       in_data;
  logic [LEN_W-1:0]            in_len;
  logic                        in_ready;
  logic                        out_valid;
  logic [OUT_WIDTH-1:0]        out_data;
  logic [OLEN_W-1:0]           out_len;
  logic                        out_last;
  logic                        out_ready;
  logic                        flush_req;
  logic                        flush_done;

  modport master (
    output in_valid, in_logb_valid, in_loge_valid, in_data, in_len, out_ready, flush_req,
    input  in_ready, out_valid, out_data, out_len, out_last, flush_done
  );

  modport slave (
    input  in_valid, in_logb_valid, in_loge_valid, in_data, in_len, out_ready, flush_req,
    output in_ready, out_valid, out_data, out_len, out_last, flush_done
  );
endinterface

// File: rtl/rr_stream_packer.sv
// Packs variable-length logging units bit-contiguously into OUT_WIDTH beats, with zero-padded flush.
// Optional statistics counters are built when RR_STREAM_PACKER_STATS_EN is defined.
module rr_stream_packer #(
  parameter int unsigned LOGB_CHANNEL_CNT = 4,
  parameter int unsigned LOGE_CHANNEL_CNT = 4,
  parameter int unsigned FULL_WIDTH       = 256,
  parameter int unsigned OUT_WIDTH        = 512
) (
  input  logic                 clk,
  input  logic                 sync_rst_n,
  rr_stream_packer_if.slave    bus
`ifdef RR_STREAM_PACKER_STATS_EN
  ,
  output logic [63:0]          stat_units,
  output logic [63:0]          stat_beats,
  output logic [31:0]          stat_flushes
`endif
);

  localparam int unsigned HDR_W    = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
  localparam int unsigned UNIT_MAX = HDR_W + FULL_WIDTH;
  localparam int unsigned LEN_W    = $clog2(FULL_WIDTH + 1);
  localparam int unsigned OLEN_W   = $clog2(OUT_WIDTH + 1);
  localparam int unsigned ACC_W    = 2 * OUT_WIDTH;
  localparam int unsigned FILL_W   = $clog2(ACC_W);

  if (UNIT_MAX > OUT_WIDTH) begin : g_bad_cfg
    $error("rr_stream_packer: HDR_W + FULL_WIDTH must not exceed OUT_WIDTH");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ACC_W-1:0]    r_acc, w_acc_sh, w_acc_nxt;
  logic [FILL_W-1:0]   r_fill, w_fill_sh, w_fill_nxt, w_unit_len;
  logic                r_in_ready, r_out_valid, r_out_last, r_flush_done;
  logic [OUT_WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic [OLEN_W-1:0]   r_out_len, w_out_len_nxt;
  logic                w_out_valid_nxt, w_out_last_nxt, w_in_ready_nxt, w_full_nxt;
  logic [LEN_W-1:0]    w_len_eff;
  logic [FULL_WIDTH-1:0] w_data_mask;
  logic [UNIT_MAX-1:0] w_unit;
  logic                w_keep, w_in_hs, w_out_hs;

  // Unit assembly: header bitmaps at the LSBs, data masked to its clamped length.
  always_comb begin
    w_len_eff   = (bus.in_len > LEN_W'(FULL_WIDTH)) ? LEN_W'(FULL_WIDTH) : bus.in_len;
    w_data_mask = ~({FULL_WIDTH{1'b1}} << w_len_eff);
    w_unit      = {bus.in_data & w_data_mask, bus.in_loge_valid, bus.in_logb_valid};
    w_unit_len  = FILL_W'(HDR_W) + FILL_W'(w_len_eff);
    w_keep      = |{bus.in_logb_valid, bus.in_loge_valid};
    w_in_hs     = bus.in_valid & r_in_ready;
    w_out_hs    = r_out_valid & bus.out_ready;
  end

  // Next state: drain the outgoing beat first, then insert the accepted unit above what remains.
  always_comb begin
    w_acc_sh    = r_acc;
    w_fill_sh   = r_fill;
    w_state_nxt = r_state;
    if (w_out_hs) begin
      w_acc_sh  = r_acc >> r_out_len;
      w_fill_sh = r_fill - FILL_W'(r_out_len);
    end
    w_acc_nxt  = w_acc_sh;
    w_fill_nxt = w_fill_sh;
    if (w_in_hs && w_keep) begin
      w_acc_nxt  = w_acc_sh | (ACC_W'(w_unit) << w_fill_sh);
      w_fill_nxt = w_fill_sh + w_unit_len;
    end

    case (r_state)
      ST_IDLE: if (bus.flush_req) w_state_nxt = ST_PEND;
      ST_PEND: if (w_fill_nxt == '0) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    w_full_nxt      = (w_fill_nxt >= FILL_W'(OUT_WIDTH));
    w_out_valid_nxt = w_full_nxt | ((w_state_nxt == ST_PEND) & (w_fill_nxt != '0));
    w_out_last_nxt  = w_out_valid_nxt & ~w_full_nxt;
    w_in_ready_nxt  = ~w_full_nxt & (w_state_nxt != ST_PEND);
    w_out_data_nxt  = w_out_valid_nxt ? w_acc_nxt[OUT_WIDTH-1:0] : '0;
    w_out_len_nxt   = '0;
    if (w_out_valid_nxt) begin
      w_out_len_nxt = w_full_nxt ? OLEN_W'(OUT_WIDTH) : OLEN_W'(w_fill_nxt);
    end
  end

  // Bits above fill are always zero, so a partial beat is implicitly zero-padded.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_fill       <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_len    <= '0;
      r_out_last   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_fill       <= w_fill_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_len    <= w_out_len_nxt;
      r_out_last   <= w_out_last_nxt;
      r_flush_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_len    = r_out_len;
  assign bus.out_last   = r_out_last;
  assign bus.flush_done = r_flush_done;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (sync_rst_n && bus.in_valid && r_in_ready)
      assert (bus.in_len <= LEN_W'(FULL_WIDTH))
      else $error("rr_stream_packer: in_len exceeds FULL_WIDTH");
  end
`endif

`ifdef RR_STREAM_PACKER_STATS_EN
  logic [63:0] r_stat_units, r_stat_beats;
  logic [31:0] r_stat_flushes;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_stat_units   <= '0;
      r_stat_beats   <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (w_in_hs && w_keep) r_stat_units <= r_stat_units + 64'd1;
      if (w_out_hs)          r_stat_beats <= r_stat_beats + 64'd1;
      if (r_flush_done)      r_stat_flushes <= r_stat_flushes + 32'd1;
    end
  end

  assign stat_units   = r_stat_units;
  assign stat_beats   = r_stat_beats;
  assign stat_flushes = r_stat_flushes;
`endif

endmodule

// File: tb/tb_rr_stream_packer.sv
// Self-checking bench for rr_stream_packer: directed cases plus randomized traffic against a bit-queue model.
module tb_rr_stream_packer;

  localparam int unsigned LOGB   = 2;
  localparam int unsigned LOGE   = 2;
  localparam int unsigned FW     = 12;
  localparam int unsigned OW     = 16;
  localparam int unsigned OLEN_W = 5;

  typedef struct {
    bit           hs;
    logic [15:0]  ad;
    logic [4:0]   al;
    logic         alast;
    logic [15:0]  ed;
    int           el;
    bit           elast;
  } beat_t;

  logic clk = 1'b0;
  logic sync_rst_n;
  always #5 clk = ~clk;

  rr_stream_packer_if #(.LOGB_CHANNEL_CNT(LOGB), .LOGE_CHANNEL_CNT(LOGE),
                        .FULL_WIDTH(FW), .OUT_WIDTH(OW)) bus ();

  rr_stream_packer #(.LOGB_CHANNEL_CNT(LOGB), .LOGE_CHANNEL_CNT(LOGE),
                     .FULL_WIDTH(FW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .bus        (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: a queue of pending stream bits plus the flush bookkeeping.
  bit mq[$];
  bit m_pend = 1'b0;
  bit m_done = 1'b0;

  function automatic bit exp_rdy();
    return (mq.size() < OW) && !m_pend;
  endfunction

  function automatic bit exp_vld();
    return (mq.size() >= OW) || (m_pend && mq.size() > 0);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_push(input logic [1:0] lb, input logic [1:0] le,
                                     input logic [11:0] d, input int len);
    if (lb == 2'b00 && le == 2'b00) return;
    for (int i = 0; i < 2; i++) mq.push_back(lb[i]);
    for (int i = 0; i < 2; i++) mq.push_back(le[i]);
    for (int i = 0; i < len && i < int'(FW); i++) mq.push_back(d[i]);
  endfunction

  function automatic void model_beat(output logic [15:0] d, output int l, output bit last);
    d    = '0;
    l    = (mq.size() >= int'(OW)) ? int'(OW) : mq.size();
    last = (mq.size() < int'(OW));
    for (int i = 0; i < l; i++) d[i] = mq.pop_front();
  endfunction

  function automatic void model_flush(input logic req);
    bit was_done;
    was_done = m_done;
    m_done   = 1'b0;
    if (m_pend) begin
      if (mq.size() == 0) begin
        m_pend = 1'b0;
        m_done = 1'b1;
      end
    end else if (req && !was_done) begin
      m_pend = 1'b1;
    end
  endfunction

  task automatic set_unit(input logic [1:0] lb, input logic [1:0] le,
                          input logic [11:0] d, input logic [3:0] len);
    bus.in_valid      = 1'b1;
    bus.in_logb_valid = lb;
    bus.in_loge_valid = le;
    bus.in_data       = d;
    bus.in_len        = len;
  endtask

  // Advance one clock: the model applies the handshakes it expects at this edge.
  task automatic tick(output beat_t b);
    bit rdy, vld;
    logic [15:0] ed;
    int el;
    bit elast;
    rdy = exp_rdy();
    vld = exp_vld();
    b.hs    = vld && (bus.out_ready === 1'b1);
    b.ad    = bus.out_data;
    b.al    = bus.out_len;
    b.alast = bus.out_last;
    ed = '0; el = 0; elast = 1'b0;
    if (b.hs) model_beat(ed, el, elast);
    b.ed = ed; b.el = el; b.elast = elast;
    if (bus.in_valid && rdy)
      model_push(bus.in_logb_valid, bus.in_loge_valid, bus.in_data, int'(bus.in_len));
    model_flush(bus.flush_req);
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_logb_valid = '0; bus.in_loge_valid = '0;
    bus.in_data = '0; bus.in_len = '0; bus.out_ready = 1'b0; bus.flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.in_ready !== 1'b0)    begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0)   begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 16'h0)   begin n_err++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    n_vec++; if (bus.out_len !== 5'd0)     begin n_err++; $display("FAIL reset_out_len got=%0d exp=0", bus.out_len); end
    n_vec++; if (bus.out_last !== 1'b0)    begin n_err++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    n_vec++; if (bus.flush_done !== 1'b0)  begin n_err++; $display("FAIL reset_flush_done got=%b exp=0", bus.flush_done); end
    sync_rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_vec++; if (bus.in_ready !== 1'b1)    begin n_err++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_single_unit();
    beat_t b;
    bus.out_ready = 1'b1;
    set_unit(2'b01, 2'b10, 12'hABC, 4'd12);
    tick(b);
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1)     begin n_err++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    n_vec++; if (bus.out_data !== 16'hABC9)  begin n_err++; $display("FAIL single_data got=%h exp=abc9", bus.out_data); end
    n_vec++; if (bus.out_len !== 5'd16)      begin n_err++; $display("FAIL single_len got=%0d exp=16", bus.out_len); end
    n_vec++; if (bus.out_last !== 1'b0)      begin n_err++; $display("FAIL single_last got=%b exp=0", bus.out_last); end
    tick(b);
    n_vec++;
    if (!b.hs || b.ad !== b.ed || b.al !== OLEN_W'(b.el) || b.alast !== b.elast) begin
      n_err++; $display("FAIL single_beat got=%h/%0d/%b exp=%h/%0d/%b", b.ad, b.al, b.alast, b.ed, b.el, b.elast);
    end
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL single_drained got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_two_short();
    beat_t b;
    set_unit(2'b01, 2'b00, 12'h005, 4'd4);
    tick(b);
    set_unit(2'b10, 2'b01, 12'h003, 4'd4);
    tick(b);
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_data !== 16'h3651 || bus.out_len !== 5'd16) begin
      n_err++; $display("FAIL two_short_beat got=%h/%0d exp=3651/16", bus.out_data, bus.out_len);
    end
    tick(b);
    n_vec++;
    if (!b.hs || b.ad !== b.ed || b.al !== OLEN_W'(b.el) || b.alast !== b.elast) begin
      n_err++; $display("FAIL two_short_model got=%h/%0d/%b exp=%h/%0d/%b", b.ad, b.al, b.alast, b.ed, b.el, b.elast);
    end
  endtask

  task automatic test_straddle_flush();
    beat_t b;
    set_unit(2'b01, 2'b00, 12'h005, 4'd4);
    tick(b);
    set_unit(2'b01, 2'b10, 12'hABC, 4'd12);
    tick(b);
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_data !== 16'hC951 || bus.out_len !== 5'd16 || bus.out_last !== 1'b0) begin
      n_err++; $display("FAIL straddle_beat got=%h/%0d/%b exp=c951/16/0", bus.out_data, bus.out_len, bus.out_last);
    end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL straddle_ready got=%b exp=0", bus.in_ready); end
    tick(b);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL straddle_residual got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    bus.flush_req = 1'b1;
    tick(b);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00AB || bus.out_len !== 5'd8 || bus.out_last !== 1'b1) begin
      n_err++; $display("FAIL flush_beat got=%b/%h/%0d/%b exp=1/00ab/8/1", bus.out_valid, bus.out_data, bus.out_len, bus.out_last);
    end
    tick(b);
    n_vec++;
    if (!b.hs || b.ad !== b.ed || b.al !== OLEN_W'(b.el) || b.alast !== b.elast) begin
      n_err++; $display("FAIL flush_model got=%h/%0d/%b exp=%h/%0d/%b", b.ad, b.al, b.alast, b.ed, b.el, b.elast);
    end
    n_vec++; if (bus.flush_done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_done_pulse got done=%b valid=%b exp done=1 valid=0", bus.flush_done, bus.out_valid);
    end
    tick(b);
    n_vec++; if (bus.flush_done !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_done_end got done=%b ready=%b exp done=0 ready=1", bus.flush_done, bus.in_ready);
    end
  endtask

  task automatic test_empty_flush();
    beat_t b;
    bus.flush_req = 1'b1;
    tick(b);
    n_vec++; if (bus.flush_done !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL empty_flush_c1 got done=%b valid=%b exp done=0 valid=0", bus.flush_done, bus.out_valid);
    end
    tick(b);
    n_vec++; if (bus.flush_done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL empty_flush_c2 got done=%b valid=%b exp done=1 valid=0", bus.flush_done, bus.out_valid);
    end
    tick(b);
    n_vec++; if (bus.flush_done !== 1'b0) begin n_err++; $display("FAIL empty_flush_c3 got done=%b exp=0", bus.flush_done); end
  endtask

  task automatic test_backpressure();
    beat_t b;
    bus.out_ready = 1'b0;
    set_unit(2'b01, 2'b10, 12'hABC, 4'd12);
    tick(b);
    set_unit(2'b10, 2'b01, 12'h003, 4'd4);
    for (int k = 0; k < 10; k++) begin
      tick(b);
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hABC9 || bus.in_ready !== 1'b0) begin
        n_err++; $display("FAIL backpressure_hold cyc=%0d got valid=%b data=%h ready=%b exp 1/abc9/0", k, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick(b);
    n_vec++;
    if (!b.hs || b.ad !== b.ed || b.al !== OLEN_W'(b.el) || b.alast !== b.elast) begin
      n_err++; $display("FAIL backpressure_beat got=%h/%0d/%b exp=%h/%0d/%b", b.ad, b.al, b.alast, b.ed, b.el, b.elast);
    end
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL backpressure_release got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_random();
    beat_t b;
    bit drained;
    for (int k = 0; k < 600; k++) begin
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.in_logb_valid = 2'($urandom_range(0, 3));
      bus.in_loge_valid = 2'($urandom_range(0, 3));
      bus.in_data       = 12'($urandom());
      bus.in_len        = 4'($urandom_range(0, 12));
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      bus.flush_req     = ($urandom_range(0, 24) == 0);
      tick(b);
      if (b.hs) begin
        n_vec++;
        if (b.ad !== b.ed || b.al !== OLEN_W'(b.el) || b.alast !== b.elast) begin
          n_err++; $display("FAIL random_beat cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, b.ad, b.al, b.alast, b.ed, b.el, b.elast);
        end
      end
      n_vec++; if (bus.in_ready !== exp_rdy())  begin n_err++; $display("FAIL random_ready cyc=%0d got=%b exp=%b", k, bus.in_ready, exp_rdy()); end
      n_vec++; if (bus.out_valid !== exp_vld()) begin n_err++; $display("FAIL random_valid cyc=%0d got=%b exp=%b", k, bus.out_valid, exp_vld()); end
      n_vec++; if (bus.flush_done !== m_done)   begin n_err++; $display("FAIL random_done cyc=%0d got=%b exp=%b", k, bus.flush_done, m_done); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick(b);
    if (!m_pend && !m_done && mq.size() > 0) bus.flush_req = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 200 && !drained; k++) begin
      tick(b);
      if (b.hs) begin
        n_vec++;
        if (b.ad !== b.ed || b.al !== OLEN_W'(b.el) || b.alast !== b.elast) begin
          n_err++; $display("FAIL drain_beat got=%h/%0d/%b exp=%h/%0d/%b", b.ad, b.al, b.alast, b.ed, b.el, b.elast);
        end
      end
      drained = !m_pend && !m_done && mq.size() == 0;
    end
    n_vec++; if (!drained || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_timeout got drained=%b valid=%b exp drained=1 valid=0", drained, bus.out_valid);
    end
  endtask

  task automatic test_reset_midop();
    beat_t b;
    bus.out_ready = 1'b0;
    set_unit(2'b01, 2'b00, 12'h005, 4'd4);
    tick(b);
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b1;
    tick(b);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_len !== 5'd8) begin
      n_err++; $display("FAIL midop_setup got valid=%b len=%0d exp valid=1 len=8", bus.out_valid, bus.out_len);
    end
    sync_rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 ||
        bus.out_len !== 5'd0 || bus.out_last !== 1'b0 || bus.flush_done !== 1'b0) begin
      n_err++; $display("FAIL midop_reset got rdy=%b vld=%b data=%h len=%0d last=%b done=%b exp all 0",
                        bus.in_ready, bus.out_valid, bus.out_data, bus.out_len, bus.out_last, bus.flush_done);
    end
    model_reset();
    sync_rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    set_unit(2'b10, 2'b01, 12'h003, 4'd4);
    tick(b);
    set_unit(2'b01, 2'b00, 12'h005, 4'd4);
    tick(b);
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h5136 || bus.out_last !== 1'b0) begin
      n_err++; $display("FAIL midop_post_beat got=%b/%h/%b exp=1/5136/0", bus.out_valid, bus.out_data, bus.out_last);
    end
    tick(b);
    n_vec++;
    if (!b.hs || b.ad !== b.ed || b.al !== OLEN_W'(b.el) || b.alast !== b.elast || bus.flush_done !== 1'b0) begin
      n_err++; $display("FAIL midop_post_model got=%h/%0d/%b done=%b exp=%h/%0d/%b done=0",
                        b.ad, b.al, b.alast, bus.flush_done, b.ed, b.el, b.elast);
    end
  endtask

  initial begin
    test_reset();
    test_single_unit();
    test_two_short();
    test_straddle_flush();
    test_empty_flush();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
